serial_dac_tx: RTL
==================

Name: serial_dac_tx

Overview:
- SPI-style write-only master that drives an external 8-bit serial DAC (DAC081S101-class frame) for the RF front-end gain and bias control.
- Accepts an 8-bit code plus a 2-bit power-down mode through a ready/enable handshake.
- Serializes a 16-bit frame MSB-first on sdata, framed by sync_n, with sclk generated from clk by an integer divider.
- Sits beside the RSSI ADC reader in the control datapath; it is the transmit counterpart of that serial-converter interface.

Parameters:
- CLK_DIV, 2, sclk half-period in clk cycles; legal range 1..255.
- GAP_CYC, 4, clk cycles that sync_n stays high after a frame before the next frame may start; legal range 1..255.

Ports:
- clk  in  1  system clock; all logic on posedge.
- resetn  in  1  synchronous, active-low reset.
- wr_en  in  1  write request; sampled only when dac_rdy=1.
- data_in  in  8  DAC code, captured with wr_en.
- pd_mode  in  2  power-down mode bits (00 normal; 01/10/11 power-down variants), captured with wr_en.
- dac_rdy  out  1  high when the block can accept wr_en.
- done  out  1  one-cycle pulse when a frame, including its gap, completes.
- wr_drop  out  1  one-cycle pulse when wr_en=1 while dac_rdy=0; the request is discarded.
- sclk  out  1  serial clock; idles high.
- sync_n  out  1  frame select, active low.
- sdata  out  1  serial data, MSB first.

Behaviour:
- Reset (resetn=0 at posedge): state IDLE, sync_n=1, sclk=1, sdata=0, dac_rdy=1, done=0, wr_drop=0, shift_reg=0, counters=0. Reset asserted mid-frame aborts immediately with the same values. The partial frame is abandoned because the DAC discards frames with fewer than 16 falling edges.
- Frame layout: {2'b00, pd_mode, data_in, 4'b0000}, bits [15:0], with bit 15 sent first.
- All outputs are registered and there are no gated clocks. sclk is a flop toggled by the divider.
- States:
  - IDLE: dac_rdy=1, sync_n=1, sclk=1, sdata=0. On wr_en=1 at posedge T: load shift_reg, and at T+1 drive sync_n=0, sdata=bit15, dac_rdy=0, div_cnt=0, edge_cnt=0, state SHIFT.
  - SHIFT: div_cnt counts 0..CLK_DIV-1. At terminal count sclk toggles and div_cnt clears.
    - sclk 1->0 (DAC sampling edge): edge_cnt increments.
    - sclk 0->1 with edge_cnt<16: shift_reg shifts left and sdata takes the next bit.
    - sclk 0->1 with edge_cnt==16: sync_n=1 and sdata=0 in the same cycle, gap_cnt=0, state GAP.
  - GAP: gap_cnt increments each cycle. When gap_cnt==GAP_CYC-1, go to IDLE: dac_rdy=1 and done=1 for one cycle.
- Timing with accept at T:
  - 1st sclk fall at T+1+CLK_DIV; k-th fall at T+1+(2k-1)*CLK_DIV.
  - sync_n rises at T+1+32*CLK_DIV.
  - dac_rdy and done assert at T+1+32*CLK_DIV+GAP_CYC.
  - Defaults: sync_n falls T+1, first fall T+3, sync_n rises T+65, ready T+69.
- sdata is stable for CLK_DIV cycles on each side of every falling sclk edge.
- wr_en at the same posedge that dac_rdy rises: not accepted. dac_rdy is the registered value, so wr_en must be held or re-asserted the next cycle; wr_drop pulses for that cycle.
- wr_en held high continuously: back-to-back frames separated by exactly GAP_CYC+1 cycles of sync_n high.
- data_in and pd_mode are don't-care except at acceptance; changing them mid-frame has no effect.
- edge_cnt is 5 bits. div_cnt and gap_cnt are 8 bits. No counter wraps in legal operation.

Decomposition:
- Package serial_dac_pkg holds the state encoding (IDLE, SHIFT, GAP as 2-bit localparams), FRAME_W=16, PD_NORMAL=2'b00, and a frame-assembly constant function.
- Natural sub-module: sclk_divider (div_cnt, terminal-count strobe, sclk flop with a load-to-idle input), reusable by the ADC reader.
- Everything else lives in one FSM module.

Test Plan:
- Reset then write data_in=8'hA5, pd_mode=00 at T:
  - sync_n low T+1..T+64.
  - 16 falling sclk edges; sampled bits = 16'h0A50.
  - done at T+69; dac_rdy low T+1..T+68.
- pd_mode=2'b11, data_in=8'h00 -> sampled frame 16'h3000; frame timing identical.
- wr_en held high with codes 8'h01 then 8'hFF:
  - two frames, 0x0010 then 0x0FF0.
  - sync_n high for exactly 5 cycles between them.
  - wr_drop pulses on every busy cycle with wr_en=1.
- resetn=0 after the 7th falling edge: next cycle sync_n=1, sclk=1, sdata=0, dac_rdy=1; a new write then produces a clean full 16-edge frame.
- CLK_DIV=1, GAP_CYC=1, write 8'h3C:
  - sampled frame 0x03C0.
  - sync_n rises at T+33; done at T+34.
- Scoreboard the whole run: sdata never changes within CLK_DIV cycles of a falling sclk edge, and sync_n never rises while sclk=0.

Source files
------------

// File: rtl/serial_dac_pkg.sv
// Shared definitions for the serial DAC transmit path: state encoding,
// frame geometry and the frame-assembly helper.
package serial_dac_pkg;

  localparam int         FRAME_W   = 16;
  localparam logic [1:0] PD_NORMAL = 2'b00;

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_SHIFT = 2'd1;
  localparam logic [1:0] ST_GAP   = 2'd2;

  typedef enum logic [1:0] {
    IDLE  = ST_IDLE,
    SHIFT = ST_SHIFT,
    GAP   = ST_GAP
  } state_t;

  // DAC frame: two don't-care leading zeros, power-down mode, code, four trailing zeros.
  function automatic logic [FRAME_W-1:0] build_frame(input logic [1:0] pd,
                                                     input logic [7:0] code);
    return {2'b00, pd, code, 4'b0000};
  endfunction

endpackage

// File: rtl/serial_dac_tx_sclk_divider.sv
// Serial-clock generator: divides clk by 2*CLK_DIV while enabled and parks
// sclk high whenever the owner is not shifting. tick flags the cycle in which
// sclk toggles so the owner can tell which edge is about to happen.
module sclk_divider #(
  parameter int CLK_DIV = 2
) (
  input  logic clk,
  input  logic resetn,
  input  logic en,
  input  logic load_idle,
  output logic tick,
  output logic sclk
);

  localparam logic [7:0] DIV_TC = 8'(CLK_DIV - 1);

  logic [7:0] div_cnt;

  assign tick = en && !load_idle && (div_cnt == DIV_TC);

  // Half-period counter and the sclk flop; idle level is high.
  always_ff @(posedge clk) begin
    if (!resetn || load_idle) begin
      div_cnt <= 8'd0;
      sclk    <= 1'b1;
    end else if (en) begin
      if (div_cnt == DIV_TC) begin
        div_cnt <= 8'd0;
        sclk    <= ~sclk;
      end else begin
        div_cnt <= div_cnt + 8'd1;
      end
    end
  end

endmodule

// File: rtl/serial_dac_tx.sv
// Write-only serial master for an 8-bit DAC081S101-class converter.
// A 16-bit frame is sent MSB first on sdata under sync_n, with sdata
// changing on rising sclk so it is centred on the DAC's falling-edge sample.
module serial_dac_tx
  import serial_dac_pkg::*;
#(
  parameter int CLK_DIV = 2,
  parameter int GAP_CYC = 4
) (
  input  logic       clk,
  input  logic       resetn,
  input  logic       wr_en,
  input  logic [7:0] data_in,
  input  logic [1:0] pd_mode,
  output logic       dac_rdy,
  output logic       done,
  output logic       wr_drop,
  output logic       sclk,
  output logic       sync_n,
  output logic       sdata
);

  localparam logic [7:0] GAP_TC  = 8'(GAP_CYC - 1);
  localparam logic [4:0] LAST_FE = 5'(FRAME_W);

  state_t               state;
  logic [FRAME_W-1:0]   shift_reg;
  logic [4:0]           edge_cnt;
  logic [7:0]           gap_cnt;
  logic [FRAME_W-1:0]   frame_in;
  logic                 tick;

  assign frame_in = build_frame(pd_mode, data_in);

  sclk_divider #(
    .CLK_DIV(CLK_DIV)
  ) u_div (
    .clk      (clk),
    .resetn   (resetn),
    .en       (state == SHIFT),
    .load_idle(state != SHIFT),
    .tick     (tick),
    .sclk     (sclk)
  );

  // Frame sequencer. shift_reg holds the bits not yet placed on sdata, next bit
  // at the MSB, so the first bit goes straight to sdata at acceptance.
  always_ff @(posedge clk) begin
    if (!resetn) begin
      state     <= IDLE;
      sync_n    <= 1'b1;
      sdata     <= 1'b0;
      dac_rdy   <= 1'b1;
      done      <= 1'b0;
      wr_drop   <= 1'b0;
      shift_reg <= '0;
      edge_cnt  <= 5'd0;
      gap_cnt   <= 8'd0;
    end else begin
      done    <= 1'b0;
      wr_drop <= wr_en && !dac_rdy;
      case (state)
        IDLE: begin
          if (wr_en) begin
            shift_reg <= {frame_in[FRAME_W-2:0], 1'b0};
            sdata     <= frame_in[FRAME_W-1];
            sync_n    <= 1'b0;
            dac_rdy   <= 1'b0;
            edge_cnt  <= 5'd0;
            state     <= SHIFT;
          end
        end
        SHIFT: begin
          if (tick) begin
            if (sclk) begin
              // Falling edge: the DAC samples the current sdata.
              edge_cnt <= edge_cnt + 5'd1;
            end else if (edge_cnt == LAST_FE) begin
              // Rising edge after the 16th sample closes the frame with sclk high.
              sync_n  <= 1'b1;
              sdata   <= 1'b0;
              gap_cnt <= 8'd0;
              state   <= GAP;
            end else begin
              sdata     <= shift_reg[FRAME_W-1];
              shift_reg <= {shift_reg[FRAME_W-2:0], 1'b0};
            end
          end
        end
        GAP: begin
          if (gap_cnt == GAP_TC) begin
            state   <= IDLE;
            dac_rdy <= 1'b1;
            done    <= 1'b1;
          end else begin
            gap_cnt <= gap_cnt + 8'd1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
